// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   BBITS_DEF / FBITS_DEF / OBITS_DEF : default (and maximum) widths of the
//                                       integer divisor, fractional divisor and
//                                       oversampling-ratio fields.
//   OSR_DEFAULT                       : customary oversampling ratio.
//   cfg_t                             : divisor/ratio configuration, used as the
//                                       shadow register of the baud generator.
//   cfg_illegal()                     : 1 when a configuration cannot produce ticks.
package uart_pkg;

  localparam int BBITS_DEF   = 16;
  localparam int FBITS_DEF   = 4;
  localparam int OBITS_DEF   = 5;
  localparam int OSR_DEFAULT = 16;

  // Fields are sized at the package widths; narrower instances zero-extend.
  typedef struct packed {
    logic [BBITS_DEF-1:0] dvsr_int;
    logic [FBITS_DEF-1:0] dvsr_frac;
    logic [OBITS_DEF-1:0] osr;
  } cfg_t;

  function automatic logic cfg_illegal(input cfg_t cfg);
    return (cfg.dvsr_int < BBITS_DEF'(2)) || (cfg.osr < OBITS_DEF'(2));
  endfunction

endpackage

// File: rtl/frac_tim.sv
// Reloadable down-counter with optional fractional accumulator.
// alarm is high while the count is zero. When alarm and en are both high
// the counter reloads with period_int + carry - 1, where carry comes from the
// fractional accumulator (acc + period_frac).
// Optional feature macro: BAUD_GEN_FRAC_EN (accumulator present when defined;
// otherwise every period is exactly period_int clocks).
// Ports:
//   clk, rst     : clock, synchronous active-high reset (count and acc to 0)
//   load         : reload count with load_int-1, clear accumulator
//   en           : advance (decrement, or reload on alarm); hold when low
//   load_int     : integer period used by load
//   period_int   : integer period used by alarm reloads
//   period_frac  : fractional period increment (1/2^FBITS clock)
//   alarm        : count is zero
module frac_tim #(
  parameter int BBITS = 16,
  parameter int FBITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [BBITS-1:0] load_int,
  input  logic [BBITS-1:0] period_int,
  input  logic [FBITS-1:0] period_frac,
  output logic             alarm
);

  logic [BBITS-1:0] cnt;
  logic             carry;

`ifdef BAUD_GEN_FRAC_EN
  logic [FBITS-1:0] acc;
  logic [FBITS-1:0] acc_nxt;

  assign {carry, acc_nxt} = {1'b0, acc} + {1'b0, period_frac};

  always_ff @(posedge clk) begin
    if (rst || load) begin
      acc <= '0;
    end else if (en && alarm) begin
      acc <= acc_nxt;
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^period_frac;
  assign carry       = 1'b0;
`endif

  assign alarm = (cnt == '0);

  // Max period is 2^BBITS (int all ones plus carry), so period-1 fits in BBITS.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_int - 1'b1;
    end else if (en) begin
      if (alarm) begin
        cnt <= period_int - 1'b1 + BBITS'(carry);
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud / oversampling tick generator for the UART.
// Produces os_tick with an average period of dvsr_int + dvsr_frac/2^FBITS
// clocks, bd_tick on the last oversampling tick of each bit and mid_tick on
// the mid-bit oversampling tick. restart realigns all phase state.
// Optional feature macro: BAUD_GEN_FRAC_EN (fractional accumulator; when
// undefined dvsr_frac is ignored and every period is exactly dvsr_int).
// Parameters must not exceed the uart_pkg default widths.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   en         : run enable; counters hold and ticks are 0 while low
//   restart    : reload configuration and zero all phase state
//   dvsr_int   : integer clocks per oversampling tick (2..2^BBITS-1)
//   dvsr_frac  : fractional clocks per oversampling tick
//   osr        : oversampling ticks per bit (2..2^OBITS-1)
//   os_tick    : oversampling pulse
//   mid_tick   : mid-bit oversampling pulse
//   bd_tick    : last oversampling pulse of each bit
//   cfg_err    : shadowed configuration illegal; ticks forced 0
module baud_gen_frac
  import uart_pkg::*;
#(
  parameter int BBITS = BBITS_DEF,
  parameter int FBITS = FBITS_DEF,
  parameter int OBITS = OBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [BBITS-1:0] dvsr_int,
  input  logic [FBITS-1:0] dvsr_frac,
  input  logic [OBITS-1:0] osr,
  output logic             os_tick,
  output logic             mid_tick,
  output logic             bd_tick,
  output logic             cfg_err
);

  cfg_t             shadow;
  cfg_t             cfg_in;
  logic             shadow_load;
  logic             alarm;
  logic [BBITS-1:0] sh_int;
  logic [FBITS-1:0] sh_frac;
  logic [OBITS-1:0] sh_osr;
  logic [OBITS-1:0] osr_last;
  logic [OBITS-1:0] osr_mid;
  logic [OBITS-1:0] ph;

  always_comb begin
    cfg_in           = '0;
    cfg_in.dvsr_int  = BBITS_DEF'(dvsr_int);
    cfg_in.dvsr_frac = FBITS_DEF'(dvsr_frac);
    cfg_in.osr       = OBITS_DEF'(osr);
  end

  // Level-based load: any idle (en=0) cycle picks up the current inputs.
  assign shadow_load = rst | restart | ~en;

  always_ff @(posedge clk) begin
    if (shadow_load) begin
      shadow <= cfg_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err <= 1'b0;
    end else if (shadow_load) begin
      cfg_err <= cfg_illegal(cfg_in);
    end
  end

  assign sh_int  = shadow.dvsr_int[BBITS-1:0];
  assign sh_frac = shadow.dvsr_frac[FBITS-1:0];
  assign sh_osr  = shadow.osr[OBITS-1:0];

  // The counter loads from the raw input on restart because the shadow is
  // being written in that same cycle.
  frac_tim #(
    .BBITS (BBITS),
    .FBITS (FBITS)
  ) u_tim (
    .clk         (clk),
    .rst         (rst),
    .load        (restart),
    .en          (en & ~cfg_err),
    .load_int    (dvsr_int),
    .period_int  (sh_int),
    .period_frac (sh_frac),
    .alarm       (alarm)
  );

  assign os_tick  = en & ~restart & ~cfg_err & alarm;
  assign osr_last = sh_osr - 1'b1;
  assign osr_mid  = (sh_osr >> 1) - 1'b1;
  assign bd_tick  = os_tick & (ph == osr_last);
  assign mid_tick = os_tick & (ph == osr_mid);

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      ph <= '0;
    end else if (os_tick) begin
      ph <= (ph == osr_last) ? '0 : ph + 1'b1;
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
`timescale 1ns/1ps
module tb_baud_gen_frac;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (default widths)
  logic        rst, en, restart;
  logic [15:0] dvsr_int;
  logic [3:0]  dvsr_frac;
  logic [4:0]  osr;
  logic        os_tick, mid_tick, bd_tick, cfg_err;

  // small instance (4-bit integer divisor) for the maximum-period case
  logic        s_en, s_restart;
  logic [3:0]  s_int;
  logic [3:0]  s_frac;
  logic [4:0]  s_osr;
  logic        s_os, s_mid, s_bd, s_err;

  int total = 0;
  int bad   = 0;

  baud_gen_frac dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .dvsr_int(dvsr_int), .dvsr_frac(dvsr_frac), .osr(osr),
    .os_tick(os_tick), .mid_tick(mid_tick), .bd_tick(bd_tick), .cfg_err(cfg_err)
  );

  baud_gen_frac #(.BBITS(4), .FBITS(4), .OBITS(5)) dut_s (
    .clk(clk), .rst(rst), .en(s_en), .restart(s_restart),
    .dvsr_int(s_int), .dvsr_frac(s_frac), .osr(s_osr),
    .os_tick(s_os), .mid_tick(s_mid), .bd_tick(s_bd), .cfg_err(s_err)
  );

  function automatic int frac_eff(input int frac);
`ifdef BAUD_GEN_FRAC_EN
    return frac;
`else
    return 0;
`endif
  endfunction

  // Expected {os,mid,bd} t cycles after the restart cycle, uninterrupted run.
  // k-th tick lands at k*int + floor((k-1)*frac/16).
  function automatic logic [2:0] model(input int t, input int di, input int df, input int os);
    int f;
    logic [2:0] r;
    f = frac_eff(df);
    r = 3'b000;
    for (int k = t / (di + 1); k <= t / di; k++) begin
      if (k >= 1 && (k * di + ((k - 1) * f) / 16) == t) begin
        r[2] = 1'b1;
        r[1] = (((k - 1) % os) == (os / 2 - 1));
        r[0] = (((k - 1) % os) == (os - 1));
      end
    end
    return r;
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; restart = 1'b0;
    dvsr_int = 16'd27; dvsr_frac = 4'd2; osr = 5'd16;
    s_en = 1'b0; s_restart = 1'b0; s_int = 4'd15; s_frac = 4'd15; s_osr = 5'd16;
    next_cyc();
    next_cyc();
    @(negedge clk);
    total++; if ({os_tick, mid_tick, bd_tick} !== 3'b000) begin bad++; $display("FAIL reset_ticks got=%b exp=000", {os_tick, mid_tick, bd_tick}); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
    total++; if ({s_os, s_mid, s_bd, s_err} !== 4'b0000) begin bad++; $display("FAIL reset_small got=%b exp=0000", {s_os, s_mid, s_bd, s_err}); end
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    total++; if ({os_tick, mid_tick, bd_tick} !== 3'b000) begin bad++; $display("FAIL post_reset_ticks got=%b exp=000", {os_tick, mid_tick, bd_tick}); end
    next_cyc();
    @(negedge clk);
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL post_reset_cfg_err got=%b exp=0", cfg_err); end
    next_cyc();
  endtask

  task automatic test_frac();
    int nos = 0;
    int nbd = 0;
    logic [2:0] exp;
    dvsr_int = 16'd27; dvsr_frac = 4'd2; osr = 5'd16; en = 1'b1; restart = 1'b1;
    @(negedge clk);
    total++; if (os_tick !== 1'b0) begin bad++; $display("FAIL frac_restart_cycle got=%b exp=0", os_tick); end
    next_cyc();
    restart = 1'b0;
    for (int t = 1; t <= 440; t++) begin
      @(negedge clk);
      exp = model(t, 27, 2, 16);
      total++; if ({os_tick, mid_tick, bd_tick} !== exp) begin bad++; $display("FAIL frac t=%0d got=%b exp=%b", t, {os_tick, mid_tick, bd_tick}, exp); end
      if (t <= 433) begin nos += int'(os_tick); nbd += int'(bd_tick); end
      next_cyc();
    end
    total++; if (nos !== 16) begin bad++; $display("FAIL frac_os_count got=%0d exp=16", nos); end
    total++; if (nbd !== 1) begin bad++; $display("FAIL frac_bd_count got=%0d exp=1", nbd); end
  endtask

  task automatic test_osr5();
    logic [2:0] exp;
    dvsr_int = 16'd4; dvsr_frac = 4'd0; osr = 5'd5; en = 1'b1; restart = 1'b1;
    next_cyc();
    restart = 1'b0;
    for (int t = 1; t <= 60; t++) begin
      @(negedge clk);
      exp = model(t, 4, 0, 5);
      total++; if ({os_tick, mid_tick, bd_tick} !== exp) begin bad++; $display("FAIL osr5 t=%0d got=%b exp=%b", t, {os_tick, mid_tick, bd_tick}, exp); end
      next_cyc();
    end
  endtask

  task automatic test_midbit_restart();
    logic [2:0] exp;
    bit seen = 1'b0;
    int first_os = -1;
    int first_bd = -1;
    dvsr_int = 16'd10; dvsr_frac = 4'd0; osr = 5'd16; en = 1'b1; restart = 1'b1;
    next_cyc();
    restart = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = bd_tick;
      next_cyc();
    end
    total++; if (!seen) begin bad++; $display("FAIL midbit_wait_bd got=none exp=bd_tick within 400 cycles"); end
    repeat (36) next_cyc();
    restart = 1'b1;
    next_cyc();
    restart = 1'b0;
    for (int t = 1; t <= 170; t++) begin
      @(negedge clk);
      exp = model(t, 10, 0, 16);
      total++; if ({os_tick, mid_tick, bd_tick} !== exp) begin bad++; $display("FAIL midbit t=%0d got=%b exp=%b", t, {os_tick, mid_tick, bd_tick}, exp); end
      if (os_tick && first_os < 0) first_os = t;
      if (bd_tick && first_bd < 0) first_bd = t;
      next_cyc();
    end
    total++; if (first_os !== 10) begin bad++; $display("FAIL midbit_first_os got=%0d exp=10", first_os); end
    total++; if (first_bd !== 160) begin bad++; $display("FAIL midbit_first_bd got=%0d exp=160", first_bd); end
  endtask

  task automatic test_en_hold();
    logic [2:0] exp;
    dvsr_int = 16'd10; dvsr_frac = 4'd0; osr = 5'd4; en = 1'b1; restart = 1'b1;
    next_cyc();
    restart = 1'b0;
    for (int t = 1; t <= 80; t++) begin
      en = !(t >= 15 && t <= 21);
      if (t == 30) dvsr_int = 16'd5;
      @(negedge clk);
      if (t < 15) exp = model(t, 10, 0, 4);
      else if (t <= 21) exp = 3'b000;
      else exp = model(t - 7, 10, 0, 4);
      total++; if ({os_tick, mid_tick, bd_tick} !== exp) begin bad++; $display("FAIL en_hold t=%0d got=%b exp=%b", t, {os_tick, mid_tick, bd_tick}, exp); end
      next_cyc();
    end
    restart = 1'b1;
    next_cyc();
    restart = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      exp = model(t, 5, 0, 4);
      total++; if ({os_tick, mid_tick, bd_tick} !== exp) begin bad++; $display("FAIL en_new_int t=%0d got=%b exp=%b", t, {os_tick, mid_tick, bd_tick}, exp); end
      next_cyc();
    end
  endtask

  task automatic test_cfg_err();
    logic [2:0] exp;
    for (int c = 0; c < 2; c++) begin
      dvsr_int = (c == 0) ? 16'd1 : 16'd8;
      osr      = (c == 0) ? 5'd16 : 5'd1;
      dvsr_frac = 4'd0; en = 1'b1; restart = 1'b1;
      next_cyc();
      restart = 1'b0;
      @(negedge clk);
      total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_err_set case=%0d got=%b exp=1", c, cfg_err); end
      for (int t = 1; t <= 30; t++) begin
        if (t > 1) @(negedge clk);
        total++; if ({os_tick, mid_tick, bd_tick} !== 3'b000) begin bad++; $display("FAIL cfg_err_ticks case=%0d t=%0d got=%b exp=000", c, t, {os_tick, mid_tick, bd_tick}); end
        next_cyc();
      end
    end
    dvsr_int = 16'd8; osr = 5'd4; restart = 1'b1;
    next_cyc();
    restart = 1'b0;
    @(negedge clk);
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_err_clear got=%b exp=0", cfg_err); end
    for (int t = 1; t <= 40; t++) begin
      if (t > 1) @(negedge clk);
      exp = model(t, 8, 0, 4);
      total++; if ({os_tick, mid_tick, bd_tick} !== exp) begin bad++; $display("FAIL cfg_legal t=%0d got=%b exp=%b", t, {os_tick, mid_tick, bd_tick}, exp); end
      next_cyc();
    end
  endtask

  task automatic test_coincident();
    logic [2:0] exp;
    dvsr_int = 16'd4; dvsr_frac = 4'd0; osr = 5'd5; en = 1'b1; restart = 1'b1;
    next_cyc();
    restart = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      if (t == 8) restart = 1'b1;
      @(negedge clk);
      exp = (t == 8) ? 3'b000 : model(t, 4, 0, 5);
      total++; if ({os_tick, mid_tick, bd_tick} !== exp) begin bad++; $display("FAIL coincident t=%0d got=%b exp=%b", t, {os_tick, mid_tick, bd_tick}, exp); end
      next_cyc();
    end
    restart = 1'b0;
    for (int t = 1; t <= 25; t++) begin
      @(negedge clk);
      exp = model(t, 4, 0, 5);
      total++; if ({os_tick, mid_tick, bd_tick} !== exp) begin bad++; $display("FAIL after_coincident t=%0d got=%b exp=%b", t, {os_tick, mid_tick, bd_tick}, exp); end
      next_cyc();
    end
  endtask

  task automatic test_max_period();
    logic [2:0] exp;
    int tk[$];
    int span_exp;
    s_int = 4'd15; s_frac = 4'd15; s_osr = 5'(OSR_DEFAULT); s_en = 1'b1; s_restart = 1'b1;
    next_cyc();
    s_restart = 1'b0;
    for (int t = 1; t <= 300; t++) begin
      @(negedge clk);
      exp = model(t, 15, 15, 16);
      total++; if ({s_os, s_mid, s_bd} !== exp) begin bad++; $display("FAIL max_period t=%0d got=%b exp=%b", t, {s_os, s_mid, s_bd}, exp); end
      if (s_os) tk.push_back(t);
      next_cyc();
    end
    span_exp = 16 * 15 + (16 * frac_eff(15)) / 16;
    total++;
    if (tk.size() < 17) begin
      bad++; $display("FAIL max_period_count got=%0d exp>=17", tk.size());
    end else if (tk[16] - tk[0] !== span_exp) begin
      bad++; $display("FAIL max_period_span got=%0d exp=%0d", tk[16] - tk[0], span_exp);
    end
    s_en = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0] exp;
    int di, df, os;
    for (int it = 0; it < 6; it++) begin
      di = $urandom_range(12, 2);
      df = $urandom_range(15, 0);
      os = $urandom_range(12, 2);
      dvsr_int = 16'(di); dvsr_frac = 4'(df); osr = 5'(os); en = 1'b1; restart = 1'b1;
      next_cyc();
      restart = 1'b0;
      for (int t = 1; t <= 150; t++) begin
        @(negedge clk);
        exp = model(t, di, df, os);
        total++; if ({os_tick, mid_tick, bd_tick} !== exp) begin bad++; $display("FAIL random it=%0d int=%0d frac=%0d osr=%0d t=%0d got=%b exp=%b", it, di, df, os, t, {os_tick, mid_tick, bd_tick}, exp); end
        next_cyc();
      end
    end
  endtask

  initial begin
    test_reset();
    test_frac();
    test_osr5();
    test_midbit_restart();
    test_en_hold();
    test_cfg_err();
    test_coincident();
    test_max_period();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
